// File: rtl/main_decoder_pkg.sv
// Shared encodings for the RV32I main control decoder: opcodes, control-word
// layout and the canned control words for each supported instruction class.
package main_decoder_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } rsltsrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Field order is the architectural bit order of the 11-bit control word.
  typedef struct packed {
    logic     regwrite;
    immsrc_e  immsrc;
    logic     alusrc;
    logic     memwrite;
    rsltsrc_e rsltsrc;
    logic     branch;
    aluop_e   aluop;
    logic     jump;
  } ctrl_t;

  localparam ctrl_t CTRL_LW    = ctrl_t'(11'b1_00_1_0_01_0_00_0);
  localparam ctrl_t CTRL_SW    = ctrl_t'(11'b0_01_1_1_00_0_00_0);
  localparam ctrl_t CTRL_RTYPE = ctrl_t'(11'b1_00_0_0_00_0_10_0);
  localparam ctrl_t CTRL_BEQ   = ctrl_t'(11'b0_10_0_0_00_1_01_0);
  localparam ctrl_t CTRL_ITYPE = ctrl_t'(11'b1_00_1_0_00_0_10_0);
  localparam ctrl_t CTRL_JAL   = ctrl_t'(11'b1_11_0_0_10_0_00_1);
  localparam ctrl_t CTRL_NOP   = ctrl_t'(11'b0_00_0_0_00_0_00_0);

endpackage

// File: rtl/main_decoder_comb.sv
// Pure combinational opcode lookup. Anything outside the supported set,
// including unknown bits, decodes to the NOP word with the illegal flag set.
module main_decoder_comb
  import main_decoder_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode to control-word table
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_LW:    ctrl = CTRL_LW;
      OP_SW:    ctrl = CTRL_SW;
      OP_RTYPE: ctrl = CTRL_RTYPE;
      OP_BEQ:   ctrl = CTRL_BEQ;
      OP_ITYPE: ctrl = CTRL_ITYPE;
      OP_JAL:   ctrl = CTRL_JAL;
      default: begin
        ctrl    = CTRL_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/main_decoder.sv
// RV32I main control decoder with registered outputs; doubles as the control
// half of the decode pipeline register (reset > flush > enable > hold).
module main_decoder
  import main_decoder_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       FLUSH,
  input  logic [6:0] OP,
  output logic [1:0] RSLTSRC,
  output logic       MEMWRITE,
  output logic       BRANCH,
  output logic       ALUSRC,
  output logic       REGWRITE,
  output logic       JUMP,
  output logic [1:0] IMMSRC,
  output logic [1:0] ALUOP,
  output logic       ILLEGAL
);

  ctrl_t ctrl_dec;
  logic  illegal_dec;
  ctrl_t ctrl_d, ctrl_q;
  logic  illegal_d, illegal_q;

  main_decoder_comb u_comb (
    .op      (OP),
    .ctrl    (ctrl_dec),
    .illegal (illegal_dec)
  );

  // Next-state selection for the output register
  always_comb begin
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (RST) begin
      ctrl_d    = CTRL_NOP;
      illegal_d = 1'b0;
    end else if (FLUSH) begin
      ctrl_d    = CTRL_NOP;
      illegal_d = 1'b0;
    end else if (EN) begin
      ctrl_d    = ctrl_dec;
      illegal_d = illegal_dec;
    end else begin
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
    end
  end

  // Output register
  always_ff @(posedge CLK) begin
    ctrl_q    <= ctrl_d;
    illegal_q <= illegal_d;
  end

  assign REGWRITE = ctrl_q.regwrite;
  assign IMMSRC   = ctrl_q.immsrc;
  assign ALUSRC   = ctrl_q.alusrc;
  assign MEMWRITE = ctrl_q.memwrite;
  assign RSLTSRC  = ctrl_q.rsltsrc;
  assign BRANCH   = ctrl_q.branch;
  assign ALUOP    = ctrl_q.aluop;
  assign JUMP     = ctrl_q.jump;
  assign ILLEGAL  = illegal_q;

endmodule

// File: tb/tb_main_decoder.sv
// Scoreboard bench for main_decoder: stimulus pushes expected outputs into a
// queue, a monitor pops and compares one entry after every rising edge.
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, flush = 1'b0;
  logic [6:0] op = 7'b0000000;
  logic [1:0] rsltsrc, immsrc, aluop;
  logic       memwrite, branch, alusrc, regwrite, jump, illegal;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];
  logic [11:0] model_state = 12'h000;

  always #5 clk = ~clk;

  main_decoder dut (
    .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .OP(op),
    .RSLTSRC(rsltsrc), .MEMWRITE(memwrite), .BRANCH(branch), .ALUSRC(alusrc),
    .REGWRITE(regwrite), .JUMP(jump), .IMMSRC(immsrc), .ALUOP(aluop),
    .ILLEGAL(illegal)
  );

  // Reference: instruction table in named fields, packed as
  // {illegal, regwrite, immsrc, alusrc, memwrite, rsltsrc, branch, aluop, jump}.
  function automatic logic [11:0] ref_decode(input logic [6:0] o);
    logic       rw = 1'b0, as = 1'b0, mw = 1'b0, br = 1'b0, jp = 1'b0, il = 1'b0;
    logic [1:0] is = 2'b00, rs = 2'b00, ao = 2'b00;
    if (o === 7'b0000011) begin rw = 1'b1; as = 1'b1; rs = 2'b01; end
    else if (o === 7'b0100011) begin is = 2'b01; as = 1'b1; mw = 1'b1; end
    else if (o === 7'b0110011) begin rw = 1'b1; ao = 2'b10; end
    else if (o === 7'b1100011) begin is = 2'b10; br = 1'b1; ao = 2'b01; end
    else if (o === 7'b0010011) begin rw = 1'b1; as = 1'b1; ao = 2'b10; end
    else if (o === 7'b1101111) begin rw = 1'b1; is = 2'b11; rs = 2'b10; jp = 1'b1; end
    else il = 1'b1;
    return {il, rw, is, as, mw, rs, br, ao, jp};
  endfunction

  task automatic step(input logic r, input logic f, input logic e,
                      input logic [6:0] o, input string nm);
    @(negedge clk);
    rst = r; flush = f; en = e; op = o;
    if (r || f) model_state = 12'h000;
    else if (e) model_state = ref_decode(op);
    exp_q.push_back(model_state);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the registered outputs just after each rising edge
  initial begin
    logic [11:0] got, want;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {illegal, regwrite, immsrc, alusrc, memwrite, rsltsrc, branch, aluop, jump};
        total++;
        if ($isunknown(got) || got !== want) begin
          bad++;
          $display("FAIL %s: got=%b expected=%b", nm, got, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IT = 7'b0010011, JL = 7'b1101111;

  initial begin
    logic [6:0] legal [6];
    logic [6:0] xop;
    legal[0] = LW; legal[1] = SW; legal[2] = RT;
    legal[3] = BQ; legal[4] = IT; legal[5] = JL;
    xop = 'x;

    step(1'b1, 1'b0, 1'b1, LW, "reset0");
    step(1'b1, 1'b0, 1'b1, LW, "reset1");
    step(1'b0, 1'b0, 1'b1, LW, "lw");
    step(1'b0, 1'b0, 1'b1, SW, "sw");
    step(1'b0, 1'b0, 1'b1, RT, "rtype");
    step(1'b0, 1'b0, 1'b1, BQ, "beq");
    step(1'b0, 1'b0, 1'b1, IT, "itype");
    step(1'b0, 1'b0, 1'b1, JL, "jal");
    step(1'b0, 1'b0, 1'b1, 7'b1111111, "illegal_ones");
    step(1'b0, 1'b0, 1'b1, xop, "illegal_x");
    step(1'b0, 1'b0, 1'b1, SW, "stall_load_sw");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, BQ, "stall_hold");
    step(1'b0, 1'b0, 1'b1, BQ, "stall_release_beq");
    step(1'b0, 1'b0, 1'b1, JL, "flush_pre_jal");
    step(1'b0, 1'b1, 1'b1, JL, "flush_en1");
    step(1'b0, 1'b0, 1'b1, JL, "flush_pre_jal2");
    step(1'b0, 1'b1, 1'b0, JL, "flush_en0");
    step(1'b0, 1'b0, 1'b1, 7'b1111111, "flush_pre_illegal");
    step(1'b0, 1'b1, 1'b0, 7'b1111111, "flush_clears_illegal");
    step(1'b0, 1'b0, 1'b1, IT, "rst_pre_itype");
    step(1'b1, 1'b1, 1'b1, RT, "rst_flush_both");
    step(1'b0, 1'b0, 1'b1, RT, "rtype_after_rst");
    step(1'b1, 1'b0, 1'b0, RT, "rst_en0");

    for (int i = 0; i < 300; i++) begin
      logic r, f, e;
      logic [6:0] o;
      r = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) o = 7'($urandom);
      else o = legal[$urandom_range(0, 5)];
      step(r, f, e, o, "random");
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- RV32I main control decoder, the first stage of the control unit.
- Decodes the 7-bit instruction opcode into datapath control signals: result mux select, memory write, branch, ALU source, register write, jump, immediate type, and ALU-op class.
- ALUOP feeds the downstream ALU decoder. BRANCH and JUMP feed the PCSRC logic.
- Outputs are registered, so the block also acts as the control half of the decode pipeline register.

Parameters:
- none. All encodings are constants in the shared package.

Ports:
- CLK       input   1  rising-edge clock
- RST       input   1  synchronous, active-high reset
- EN        input   1  register update enable; low = hold all outputs (stall)
- FLUSH     input   1  synchronous bubble insert; forces outputs to NOP next edge
- OP        input   7  instruction opcode, bits [6:0]
- RSLTSRC   output  2  result mux select: 00 = ALU, 01 = data memory, 10 = PC+4
- MEMWRITE  output  1  data memory write enable
- BRANCH    output  1  branch instruction, ANDed with Zero for PCSRC
- ALUSRC    output  1  ALU B input select: 0 = register, 1 = immediate
- REGWRITE  output  1  register file write enable
- JUMP      output  1  jump instruction, ORed into PCSRC
- IMMSRC    output  2  extend type: 00 = I, 01 = S, 10 = B, 11 = J
- ALUOP     output  2  ALU decoder class: 00 = add, 01 = subtract/compare, 10 = funct-decoded
- ILLEGAL   output  1  registered flag: opcode not in the supported set

Behaviour:
- Combinational decode of OP into an 11-bit control word. Bit order, MSB to LSB: REGWRITE, IMMSRC[1:0], ALUSRC, MEMWRITE, RSLTSRC[1:0], BRANCH, ALUOP[1:0], JUMP.
- Decode table, written as REGWRITE / IMMSRC / ALUSRC / MEMWRITE / RSLTSRC / BRANCH / ALUOP / JUMP:
  - lw   0000011: 1 / 00 / 1 / 0 / 01 / 0 / 00 / 0
  - sw   0100011: 0 / 01 / 1 / 1 / 00 / 0 / 00 / 0
  - R    0110011: 1 / 00 / 0 / 0 / 00 / 0 / 10 / 0 (IMMSRC is don't-care and is driven 00)
  - beq  1100011: 0 / 10 / 0 / 0 / 00 / 1 / 01 / 0
  - I    0010011: 1 / 00 / 1 / 0 / 00 / 0 / 10 / 0
  - jal  1101111: 1 / 11 / 0 / 0 / 10 / 0 / 00 / 1
- Any other opcode, including X/Z on OP: control word = all zeros (NOP: no register write, no memory write, no branch/jump) and ILLEGAL = 1. Outputs never carry X.
- Registered outputs: the decode of OP sampled at rising edge N appears on the outputs after edge N. Latency is 1 cycle.
- Update priority at each rising edge:
  - RST = 1: all outputs 0, including ILLEGAL.
  - else FLUSH = 1: all outputs 0, ILLEGAL = 0.
  - else EN = 1: load the decoded word and ILLEGAL.
  - else: hold the previous values.
- Reset value of every output is 0. Reset asserted mid-stream zeroes the outputs on the next edge regardless of EN and FLUSH.
- FLUSH wins over EN when both are high. FLUSH is honoured while EN = 0.
- No internal state other than the 12 output flops. No handshake.

Decomposition:
- Package main_decoder_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ITYPE, OP_JAL;
  - the packed control-word struct ctrl_t, fields in the bit order above;
  - constants CTRL_LW, CTRL_SW, CTRL_RTYPE, CTRL_BEQ, CTRL_ITYPE, CTRL_JAL, CTRL_NOP;
  - enums for IMMSRC, RSLTSRC and ALUOP.
- One sub-module is natural: main_decoder_comb, a pure combinational OP to {ctrl_t, illegal} lookup. The top wraps it with the output register and the RST/FLUSH/EN priority.

Test Plan:
- RST = 1 for 2 cycles while OP = lw -> every output 0, ILLEGAL = 0. Release RST with EN = 1 and OP = lw -> one edge later RSLTSRC = 01, ALUSRC = 1, REGWRITE = 1, all others 0.
- EN = 1, apply each opcode on successive cycles (sw, R, beq, I, jal) -> each control word matches the table one cycle after it is applied. Example: jal gives IMMSRC = 11, RSLTSRC = 10, JUMP = 1, REGWRITE = 1.
- OP = 1111111, then OP = 7'bx -> control outputs all 0 and ILLEGAL = 1 for both; no X appears on any output.
- OP = sw with EN = 1, then EN = 0 and OP changed to beq for 3 cycles -> MEMWRITE stays 1 and IMMSRC stays 01 through the stall. Raise EN -> BRANCH = 1, ALUOP = 01.
- OP = jal with EN = 1, then FLUSH = 1 and EN = 1 -> outputs all 0 after the flush edge. Repeat with FLUSH = 1 and EN = 0 -> also all 0.
- RST and FLUSH asserted together mid-sequence with OP = R -> outputs 0. Deassert both -> R-type word appears one edge later.
